inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_if.sv | 37 +++
 rtl/inst_fetch_ctrl.sv | 97 +++++++++
 tb/tb_inst_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bundle: ROM bus plus the
// IF->ID queue head and redirect inputs.
interface inst_fetch_ctrl_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_inst_i,
    input  branch_flag_i,
    input  branch_target_address_i,
    input  id_ready_i,
    output if_valid_o,
    output if_pc_o,
    output if_inst_o
  );

  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_inst_i,
    output branch_flag_i,
    output branch_target_address_i,
    output id_ready_i,
    input  if_valid_o,
    input  if_pc_o,
    input  if_inst_o
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller with a
// small prefetch queue and redirect flush.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_ctrl_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {OFF, FETCH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic run, valid, pop, push;

  assign run   = (state_q == FETCH);
  assign valid = (cnt_q != '0);
  assign pop   = run & valid
               & bus.id_ready_i
               & ~bus.branch_flag_i;
  assign push  = run & ~bus.branch_flag_i
               & ((cnt_q < FULL) | pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      OFF: state_d = FETCH;
      FETCH: begin
        if (bus.branch_flag_i) begin
          cnt_d  = '0;
          head_d = '0;
          tail_d = '0;
          pc_d   = {bus.branch_target_address_i[31:2],
                    2'b00};
        end else begin
          if (push) begin
            tail_d = tail_q + PW'(1);
            pc_d   = pc_q + 32'd4;
          end
          if (pop) head_d = head_q + PW'(1);
          if (push & ~pop)
            cnt_d = cnt_q + CW'(1);
          else if (pop & ~push)
            cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage needs no reset: reads are gated by valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= bus.rom_inst_i;
    end
  end

  assign bus.rom_ce_o   = push;
  assign bus.rom_addr_o = pc_q;
  assign bus.if_valid_o = valid;
  assign bus.if_pc_o    = valid ? pc_mem[head_q]
                                : 32'h0;
  assign bus.if_inst_o  = valid ? inst_mem[head_q]
                                : 32'h0;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench: three fetch controllers driven in lockstep
// against a queue-based reference model.
module tb_inst_fetch_ctrl;
  logic        clk = 0;
  logic        rst, rdy, br;
  logic [31:0] tgt;
  int          nchk = 0;
  int          nerr = 0;
  bit          en = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h3401_0011;
    return a * 32'h0001_0003 + 32'h0000_1357;
  endfunction

  inst_fetch_ctrl_if b0();
  inst_fetch_ctrl_if b1();
  inst_fetch_ctrl_if b2();

  assign b0.branch_flag_i = br;
  assign b0.branch_target_address_i = tgt;
  assign b0.id_ready_i = rdy;
  assign b0.rom_inst_i = b0.rom_ce_o ? rom(b0.rom_addr_o) : 32'h0;
  assign b1.branch_flag_i = br;
  assign b1.branch_target_address_i = tgt;
  assign b1.id_ready_i = rdy;
  assign b1.rom_inst_i = b1.rom_ce_o ? rom(b1.rom_addr_o) : 32'h0;
  assign b2.branch_flag_i = br;
  assign b2.branch_target_address_i = tgt;
  assign b2.id_ready_i = rdy;
  assign b2.rom_inst_i = b2.rom_ce_o ? rom(b2.rom_addr_o) : 32'h0;

  inst_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(4))
    dut0 (.clk(clk), .rst(rst), .bus(b0.master));
  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4))
    dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  inst_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2))
    dut2 (.clk(clk), .rst(rst), .bus(b2.master));

  logic        o_ce [3];
  logic        o_v  [3];
  logic [31:0] o_addr [3];
  logic [31:0] o_pc   [3];
  logic [31:0] o_inst [3];

  assign o_ce[0] = b0.rom_ce_o;   assign o_v[0] = b0.if_valid_o;
  assign o_addr[0] = b0.rom_addr_o;
  assign o_pc[0] = b0.if_pc_o;    assign o_inst[0] = b0.if_inst_o;
  assign o_ce[1] = b1.rom_ce_o;   assign o_v[1] = b1.if_valid_o;
  assign o_addr[1] = b1.rom_addr_o;
  assign o_pc[1] = b1.if_pc_o;    assign o_inst[1] = b1.if_inst_o;
  assign o_ce[2] = b2.rom_ce_o;   assign o_v[2] = b2.if_valid_o;
  assign o_addr[2] = b2.rom_addr_o;
  assign o_pc[2] = b2.if_pc_o;    assign o_inst[2] = b2.if_inst_o;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: queue of {pc,inst}, fetch pc, running flag
  int          dep [3] = '{4, 4, 2};
  logic [31:0] rpc [3] = '{32'h0, 32'hFFFF_FFF8, 32'h0};
  logic [63:0] mq  [3][$];
  logic [31:0] mpc [3];
  bit          run [3];

  function automatic bit m_pop(input int k);
    return run[k] && mq[k].size() != 0 && rdy && !br;
  endfunction

  function automatic bit m_ce(input int k);
    return run[k] && !br && (mq[k].size() < dep[k] || m_pop(k));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit p, c;
      p = m_pop(k);
      c = m_ce(k);
      if (rst) begin
        mq[k].delete();
        mpc[k] = rpc[k];
        run[k] = 0;
      end else if (!run[k]) begin
        run[k] = 1;
      end else if (br) begin
        mq[k].delete();
        mpc[k] = {tgt[31:2], 2'b00};
      end else begin
        if (p) void'(mq[k].pop_front());
        if (c) begin
          mq[k].push_back({mpc[k], rom(mpc[k])});
          mpc[k] = mpc[k] + 32'd4;
        end
      end
    end
    en = 1;
  end

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        bit          v;
        logic [63:0] h;
        v = mq[k].size() != 0;
        h = v ? mq[k][0] : 64'h0;
        chk($sformatf("m%0d ce", k), o_ce[k], m_ce(k));
        chk($sformatf("m%0d addr", k), o_addr[k], mpc[k]);
        chk($sformatf("m%0d valid", k), o_v[k], v);
        chk($sformatf("m%0d pc", k), o_pc[k], h[63:32]);
        chk($sformatf("m%0d inst", k), o_inst[k], h[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; br = 0; tgt = 32'h0;
    repeat (3) tick();
    rst = 0; #1;
    chk("exit ce off", o_ce[0], 0);
    chk("exit valid", o_v[0], 0);
    tick(); #1;
    chk("exit ce on", o_ce[0], 1);
    chk("exit addr", o_addr[0], 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("stream valid", o_v[0], 1);
      chk("stream pc", o_pc[0], 32'(4 * i));
      if (i == 0) chk("word0", o_inst[0], 32'h3401_0011);
      if (i < 3)
        chk("wrap pc", o_pc[1], 32'hFFFF_FFF8 + 32'(4 * i));
    end
    rdy = 0;
    tick(); #1;
    chk("two queued", o_v[1], 1);
    rst = 1;
    tick(); #1;
    chk("rst valid0", o_v[0], 0);
    chk("rst valid1", o_v[1], 0);
    chk("rst addr1", o_addr[1], 32'hFFFF_FFF8);
    chk("rst ce0", o_ce[0], 0);

    tick();
    rst = 0; #1;
    chk("fill off", o_ce[0], 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("fill ce", o_ce[0], 1);
      chk("fill addr", o_addr[0], 32'(4 * i));
    end
    repeat (2) begin
      tick(); #1;
      chk("full ce", o_ce[0], 0);
      chk("full addr", o_addr[0], 32'h10);
      chk("full head", o_pc[0], 32'h0);
      chk("d2 full ce", o_ce[2], 0);
      chk("d2 full addr", o_addr[2], 32'h8);
    end
    rdy = 1; #1;
    chk("resume ce", o_ce[0], 1);
    chk("resume addr", o_addr[0], 32'h10);
    for (int i = 1; i < 5; i++) begin
      tick(); #1;
      chk("drain pc", o_pc[0], 32'(4 * i));
    end

    rdy = 0;
    tick(); #1;
    chk("stall full ce", o_ce[0], 0);
    br = 1; tgt = 32'h0000_0042; #1;
    chk("br ce", o_ce[0], 0);
    chk("br valid", o_v[0], 1);
    tick();
    br = 0; #1;
    chk("post br valid", o_v[0], 0);
    chk("post br addr", o_addr[0], 32'h40);
    chk("post br ce", o_ce[0], 1);
    tick(); #1;
    chk("tgt valid", o_v[0], 1);
    chk("tgt pc", o_pc[0], 32'h40);
    chk("tgt inst", o_inst[0], rom(32'h40));

    br = 1; tgt = 32'h100; #1;
    chk("hold br ce", o_ce[0], 0);
    tick();
    tgt = 32'h207; #1;
    chk("hold br valid", o_v[0], 0);
    chk("hold br ce2", o_ce[0], 0);
    tick();
    br = 0; #1;
    chk("latest valid", o_v[0], 0);
    chk("latest addr", o_addr[0], 32'h204);
    chk("latest ce", o_ce[0], 1);
    tick(); #1;
    chk("latest pc", o_pc[0], 32'h204);
    rdy = 1;
    repeat (6) tick();
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
